mem_port_master: RTL and testbench

Single-port memory initiator that sits between the core's fetch and load/store stages and the unified byte-addressable instruction/data memory. Each cycle at most one of two requesters, fetch or data, owns the memory port. The block arbitrates between them and drives the memory's `mem_op`/`addr`/`dataIn`. It captures the byte-rotated read word and returns sign- or zero-extended load data to the core through a req/ack handshake.

---
 rtl/mem_port_master_if.sv | 43 ++++
 rtl/mem_port_master.sv | 110 +++++++++++
 tb/tb_mem_port_master.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_master_if.sv
// Bundle of the fetch port, data port and memory port signals seen by mem_port_master.
// Handshake: a requester raises req and holds it (with its fields stable) until the single-cycle ack;
// an ack completes exactly one access, and the same req is only re-accepted after the ack cycle.
interface mem_port_master_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;

  logic [1:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_op, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_op, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_master.sv
// Single-port memory initiator: arbitrates fetch vs data onto one byte-addressed memory
// port and returns fetched words and sign/zero-extended load data via req/ack.
module mem_port_master #(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_master_if.master    bus,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state, state_nx;
  logic        last_grant;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        if_elig, d_elig;
  logic        grant_if, grant_d;
  logic [1:0]  store_op;
  logic [31:0] load_ext;

  // A port still showing its ack is finishing; its held-high req must not start a new access.
  assign if_elig = bus.if_req && !bus.if_ack;
  assign d_elig  = bus.d_req  && !bus.d_ack;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (if_elig && d_elig) begin
          if (last_grant == GRANT_F) grant_d = 1'b1;
          else                       grant_if = 1'b1;
        end else begin
          grant_if = if_elig;
          grant_d  = d_elig;
        end
        if (grant_if)                  state_nx = S_FETCH;
        else if (grant_d && bus.d_we)  state_nx = S_STORE;
        else if (grant_d)              state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    case (bus.d_size)
      2'b00:   store_op = 2'b01;
      2'b01:   store_op = 2'b10;
      default: store_op = 2'b11;
    endcase
  end

  always_comb begin
    load_ext = bus.mem_rdata;
    case (req_size)
      2'b00:   load_ext = {{24{~req_unsigned & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
      2'b01:   load_ext = {{16{~req_unsigned & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= GRANT_F;
      req_size      <= 2'b00;
      req_unsigned  <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.mem_op    <= 2'b00;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.if_ack <= (state == S_FETCH);
      bus.d_ack  <= (state == S_LOAD) || (state == S_STORE);
      bus.mem_op <= 2'b00;
      if (grant_if) begin
        last_grant   <= GRANT_F;
        bus.mem_addr <= bus.if_addr;
      end
      if (grant_d) begin
        last_grant    <= GRANT_D;
        req_size      <= bus.d_size;
        req_unsigned  <= bus.d_unsigned;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        if (bus.d_we) bus.mem_op <= store_op;
      end
      if (state == S_FETCH) bus.if_rdata <= bus.mem_rdata;
      if (state == S_LOAD)  bus.d_rdata  <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a byte-addressed little-endian memory model.
module tb_mem_port_master;
  localparam int ADDR_W = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] state_dbg;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  mem_port_master_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_master #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // memory model: combinational read, store committed on the edge ending the store cycle
  logic [7:0]  mem [0:1023];
  logic        poke_en, clear_en;
  logic [9:0]  poke_addr;
  logic [7:0]  poke_byte;

  always @(posedge clk) begin
    if (clear_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_byte;
    end else begin
      case (bus.mem_op)
        2'b01: mem[bus.mem_addr] <= bus.mem_wdata[7:0];
        2'b10: begin
          mem[bus.mem_addr]         <= bus.mem_wdata[7:0];
          mem[bus.mem_addr + 10'd1] <= bus.mem_wdata[15:8];
        end
        2'b11: begin
          mem[bus.mem_addr]         <= bus.mem_wdata[7:0];
          mem[bus.mem_addr + 10'd1] <= bus.mem_wdata[15:8];
          mem[bus.mem_addr + 10'd2] <= bus.mem_wdata[23:16];
          mem[bus.mem_addr + 10'd3] <= bus.mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_rdata = {mem[bus.mem_addr + 10'd3], mem[bus.mem_addr + 10'd2],
                     mem[bus.mem_addr + 10'd1], mem[bus.mem_addr]};
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] b);
    poke_en = 1'b1; poke_addr = a; poke_byte = b;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic start_data(input logic we, input logic [1:0] size, input logic uns,
                            input logic [9:0] a, input logic [31:0] wd);
    bus.d_we = we; bus.d_size = size; bus.d_unsigned = uns;
    bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
  endtask

  task automatic stop_data();
    bus.d_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    poke_en = 1'b0; poke_addr = '0; poke_byte = '0;
    clear_en = 1'b1;
    tick();
    tick();
    clear_en = 1'b0;
    chk_cnt++;
    if ({bus.if_ack, bus.d_ack, busy, state_dbg, bus.mem_op, bus.mem_addr, bus.mem_wdata,
         bus.if_rdata, bus.d_rdata} !== '0)
      $display("FAIL reset_values: got ack=%b/%b busy=%b st=%0d op=%0d addr=%h wd=%h ifr=%h dr=%h, required all 0",
               bus.if_ack, bus.d_ack, busy, state_dbg, bus.mem_op, bus.mem_addr, bus.mem_wdata,
               bus.if_rdata, bus.d_rdata);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic       e_busy, e_dack, e_iack;
    logic [1:0] e_op;
    logic [9:0] e_addr;
    rst = 1'b1;
    bus.if_addr = 10'h010; bus.if_req = 1'b1;
    start_data(1'b1, 2'b10, 1'b0, 10'h200, 32'hA5A5A5A5);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e_busy = (k % 2 == 0);
      e_op   = (k % 4 == 0) ? 2'b11 : 2'b00;
      e_addr = (k % 4 < 2) ? 10'h200 : 10'h010;
      e_dack = (k % 4 == 1);
      e_iack = (k % 4 == 3);
      chk_cnt++;
      if ({busy, bus.mem_op, bus.mem_addr, bus.d_ack, bus.if_ack} !== {e_busy, e_op, e_addr, e_dack, e_iack})
        $display("FAIL contention[%0d]: got busy=%b op=%0d addr=%h dack=%b iack=%b, required busy=%b op=%0d addr=%h dack=%b iack=%b",
                 k, busy, bus.mem_op, bus.mem_addr, bus.d_ack, bus.if_ack,
                 e_busy, e_op, e_addr, e_dack, e_iack);
      else pass_cnt++;
    end
    bus.if_req = 1'b0;
    stop_data();
    tick();
    tick();
  endtask

  task automatic test_fetch();
    poke(10'h010, 8'h93); poke(10'h011, 8'h00); poke(10'h012, 8'h50); poke(10'h013, 8'h00);
    bus.if_addr = 10'h010; bus.if_req = 1'b1;
    tick();
    chk_cnt++;
    if ({busy, bus.mem_op, bus.mem_addr, bus.if_ack} !== {1'b1, 2'b00, 10'h010, 1'b0})
      $display("FAIL fetch_access: got busy=%b op=%0d addr=%h ack=%b, required 1 0 010 0",
               busy, bus.mem_op, bus.mem_addr, bus.if_ack);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.if_ack, bus.if_rdata, bus.mem_op} !== {1'b1, 32'h00500093, 2'b00})
      $display("FAIL fetch_ack: got ack=%b rdata=%h op=%0d, required 1 00500093 0",
               bus.if_ack, bus.if_rdata, bus.mem_op);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.if_ack, busy} !== 2'b00)
      $display("FAIL fetch_no_reissue: got ack=%b busy=%b, required 0 0", bus.if_ack, busy);
    else pass_cnt++;
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    poke(10'h023, 8'h80);
    start_data(1'b0, 2'b00, 1'b0, 10'h023, 32'h0);
    tick();
    chk_cnt++;
    if ({busy, bus.mem_op, bus.mem_addr} !== {1'b1, 2'b00, 10'h023})
      $display("FAIL load_byte_access: got busy=%b op=%0d addr=%h, required 1 0 023",
               busy, bus.mem_op, bus.mem_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'hFFFFFF80})
      $display("FAIL load_byte_signed: got ack=%b rdata=%h, required 1 ffffff80", bus.d_ack, bus.d_rdata);
    else pass_cnt++;
    stop_data();
    tick();
    start_data(1'b0, 2'b00, 1'b1, 10'h023, 32'h0);
    tick();
    tick();
    chk_cnt++;
    if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h00000080})
      $display("FAIL load_byte_unsigned: got ack=%b rdata=%h, required 1 00000080", bus.d_ack, bus.d_rdata);
    else pass_cnt++;
    stop_data();
    tick();
  endtask

  task automatic test_store_load();
    start_data(1'b1, 2'b01, 1'b0, 10'h102, 32'h1234BEEF);
    tick();
    chk_cnt++;
    if ({bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.d_ack} !== {2'b10, 10'h102, 32'h1234BEEF, 1'b0})
      $display("FAIL store_half_access: got op=%0d addr=%h wdata=%h ack=%b, required 2 102 1234beef 0",
               bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.d_ack);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.mem_op, bus.d_ack, bus.d_rdata} !== {2'b00, 1'b1, 32'h00000080})
      $display("FAIL store_half_ack: got op=%0d ack=%b rdata=%h, required 0 1 00000080 (held)",
               bus.mem_op, bus.d_ack, bus.d_rdata);
    else pass_cnt++;
    stop_data();
    tick();
    chk_cnt++;
    if (bus.d_ack !== 1'b0)
      $display("FAIL store_ack_pulse: got ack=%b, required 0", bus.d_ack);
    else pass_cnt++;
    start_data(1'b0, 2'b10, 1'b0, 10'h100, 32'h0);
    tick();
    tick();
    chk_cnt++;
    if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'hBEEF0000})
      $display("FAIL load_word_after_store: got ack=%b rdata=%h, required 1 beef0000", bus.d_ack, bus.d_rdata);
    else pass_cnt++;
    stop_data();
    tick();
    start_data(1'b0, 2'b01, 1'b0, 10'h101, 32'h0);
    tick();
    tick();
    chk_cnt++;
    if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'hFFFFEF00})
      $display("FAIL load_half_unaligned: got ack=%b rdata=%h, required 1 ffffef00", bus.d_ack, bus.d_rdata);
    else pass_cnt++;
    stop_data();
    tick();
  endtask

  task automatic test_wrap();
    poke(10'h3FE, 8'h11); poke(10'h3FF, 8'h22); poke(10'h000, 8'h33); poke(10'h001, 8'h44);
    for (int s = 2; s < 4; s++) begin
      start_data(1'b0, 2'(s), 1'b0, 10'h3FE, 32'h0);
      tick();
      chk_cnt++;
      if (bus.mem_addr !== 10'h3FE)
        $display("FAIL wrap_addr[size=%0d]: got %h, required 3fe", s, bus.mem_addr);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h44332211})
        $display("FAIL wrap_data[size=%0d]: got ack=%b rdata=%h, required 1 44332211", s, bus.d_ack, bus.d_rdata);
      else pass_cnt++;
      stop_data();
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    start_data(1'b1, 2'b10, 1'b0, 10'h104, 32'hDEADBEEF);
    tick();
    chk_cnt++;
    if ({bus.mem_op, busy} !== {2'b11, 1'b1})
      $display("FAIL mid_reset_setup: got op=%0d busy=%b, required 3 1", bus.mem_op, busy);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.if_ack, bus.d_ack, busy, bus.mem_op, bus.mem_addr, bus.mem_wdata,
         bus.if_rdata, bus.d_rdata} !== '0)
      $display("FAIL mid_reset_async: got ack=%b/%b busy=%b op=%0d addr=%h wd=%h ifr=%h dr=%h, required all 0",
               bus.if_ack, bus.d_ack, busy, bus.mem_op, bus.mem_addr, bus.mem_wdata,
               bus.if_rdata, bus.d_rdata);
    else pass_cnt++;
    stop_data();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cnt++;
      if ({bus.d_ack, busy} !== 2'b00)
        $display("FAIL mid_reset_no_ack[%0d]: got ack=%b busy=%b, required 0 0", k, bus.d_ack, busy);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({mem[10'h107], mem[10'h106], mem[10'h105], mem[10'h104]} !== 32'h0)
      $display("FAIL mid_reset_no_commit: got %h, required 00000000",
               {mem[10'h107], mem[10'h106], mem[10'h105], mem[10'h104]});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fetch();
    test_load_byte();
    test_store_load();
    test_wrap();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $fatal(1);
  end

endmodule
